id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage of the RV32I core: captures decoded fields from ID, derives the 4-bit ALU operation, resolves operand forwarding from EX/MEM and MEM/WB, and presents `alu_op`, `alu_a`, `alu_b` directly to the ALU in the EX stage. It also detects load-use hazards and inserts the required bubble.

---
 rtl/id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: decodes the ALU operation, selects
// forwarded operands for the EX-stage ALU and inserts load-use bubbles.

module fwd_mux (
    input  logic [4:0]  rs,
    input  logic [31:0] rf_data,
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_regwrite,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic [31:0] data
);
    logic exm_hit, mwb_hit;

    // x0 is hardwired, so a write to it is never a forward source
    assign exm_hit = exm_regwrite && (exm_rd != 5'd0) && (exm_rd == rs);
    assign mwb_hit = mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == rs);
    assign data    = exm_hit ? exm_result : (mwb_hit ? mwb_result : rf_data);
endmodule

module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            stall,
    input  logic            flush,
    input  logic            exm_regwrite,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_regwrite,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_illegal,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] ex_pc,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] ex_store_data
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] A_RS   = 2'd0;
    localparam logic [1:0] A_ZERO = 2'd1;
    localparam logic [1:0] A_PC   = 2'd2;
    localparam logic [1:0] B_RS   = 2'd0;
    localparam logic [1:0] B_FOUR = 2'd1;
    localparam logic [1:0] B_IMM  = 2'd2;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            illegal;
        logic [3:0]      alu_op;
        logic [1:0]      a_sel;
        logic [1:0]      b_sel;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } ex_state_t;

    ex_state_t ex_q, ex_d, ld, bub;

    logic [3:0] d_alu_op;
    logic       d_rw, d_mr, d_mw, d_br, d_ill;
    logic [1:0] d_asel, d_bsel;

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                            input logic is_reg);
        case (f3)
            3'b000:  arith_op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        d_alu_op = ALU_ADD;
        d_rw     = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_br     = 1'b0;
        d_ill    = 1'b0;
        d_asel   = A_RS;
        d_bsel   = B_IMM;
        case (id_opcode)
            OPC_OP: begin
                d_rw     = 1'b1;
                d_bsel   = B_RS;
                d_alu_op = arith_op(id_funct3, id_funct7b5, 1'b1);
            end
            OPC_OPIMM: begin
                d_rw     = 1'b1;
                d_alu_op = arith_op(id_funct3, id_funct7b5, 1'b0);
            end
            OPC_LOAD: begin
                d_rw = 1'b1;
                d_mr = 1'b1;
            end
            OPC_STORE: d_mw = 1'b1;
            OPC_BRANCH: begin
                d_br   = 1'b1;
                d_bsel = B_RS;
                case (id_funct3[2:1])
                    2'b10:   d_alu_op = ALU_SLT;
                    2'b11:   d_alu_op = ALU_SLTU;
                    default: d_alu_op = ALU_SUB;
                endcase
            end
            OPC_LUI: begin
                d_rw   = 1'b1;
                d_asel = A_ZERO;
            end
            OPC_AUIPC: begin
                d_rw   = 1'b1;
                d_asel = A_PC;
            end
            OPC_JAL, OPC_JALR: begin
                d_rw   = 1'b1;
                d_asel = A_PC;
                d_bsel = B_FOUR;
            end
            default: d_ill = 1'b1;
        endcase
    end

    // Load-use: the loaded value is not available to forward until MEM/WB
    assign hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                          ((id_rs1 == ex_q.rd) ||
                           ((id_rs2 == ex_q.rd) &&
                            ((id_opcode == OPC_OP) || (id_opcode == OPC_STORE) ||
                             (id_opcode == OPC_BRANCH))));

    always_comb begin
        bub        = '0;
        bub.alu_op = ALU_ADD;

        ld           = '0;
        ld.valid     = 1'b1;
        ld.reg_write = d_rw && (id_rd != 5'd0);
        ld.mem_read  = d_mr;
        ld.mem_write = d_mw;
        ld.branch    = d_br;
        ld.illegal   = d_ill;
        ld.alu_op    = d_alu_op;
        ld.a_sel     = d_asel;
        ld.b_sel     = d_bsel;
        ld.rd        = id_rd;
        ld.rs1       = id_rs1;
        ld.rs2       = id_rs2;
        ld.funct3    = id_funct3;
        ld.pc        = id_pc;
        ld.imm       = id_imm;
        ld.rs1_data  = id_rs1_data;
        ld.rs2_data  = id_rs2_data;

        if (flush)
            ex_d = bub;
        else if (stall)
            ex_d = ex_q;
        else if (hazard_stall || !id_valid)
            ex_d = bub;
        else
            ex_d = ld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            ex_q.alu_op <= ALU_ADD;
        end else begin
            ex_q <= ex_d;
        end
    end

    logic [1:0][4:0]      fw_rs;
    logic [1:0][XLEN-1:0] fw_rf;
    logic [1:0][XLEN-1:0] fw_out;

    assign fw_rs = {ex_q.rs2, ex_q.rs1};
    assign fw_rf = {ex_q.rs2_data, ex_q.rs1_data};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_fwd
            fwd_mux u_fwd (
                .rs           (fw_rs[g]),
                .rf_data      (fw_rf[g]),
                .exm_regwrite (exm_regwrite),
                .exm_rd       (exm_rd),
                .exm_result   (exm_result),
                .mwb_regwrite (mwb_regwrite),
                .mwb_rd       (mwb_rd),
                .mwb_result   (mwb_result),
                .data         (fw_out[g])
            );
        end
    endgenerate

    logic [XLEN-1:0] b_raw;
    logic            is_shift;

    assign is_shift = (ex_q.alu_op == ALU_SLL) || (ex_q.alu_op == ALU_SRL) ||
                      (ex_q.alu_op == ALU_SRA);

    always_comb begin
        case (ex_q.a_sel)
            A_ZERO:  alu_a = '0;
            A_PC:    alu_a = ex_q.pc;
            default: alu_a = fw_out[0];
        endcase
        case (ex_q.b_sel)
            B_RS:    b_raw = fw_out[1];
            B_FOUR:  b_raw = XLEN'(4);
            default: b_raw = ex_q.imm;
        endcase
        alu_b = is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
    end

    assign ex_store_data = fw_out[1];
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_illegal    = ex_q.illegal;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_pc         = ex_q.pc;
    assign alu_op        = ex_q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model checked every
// falling edge, plus literal expectations from hand-worked cases.

module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_imm = '0, id_rs1_data = '0, id_rs2_data = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [6:0]  id_opcode = '0;
    logic [2:0]  id_funct3 = '0;
    logic        id_funct7b5 = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        exm_regwrite = 1'b0, mwb_regwrite = 1'b0;
    logic [4:0]  exm_rd = '0, mwb_rd = '0;
    logic [31:0] exm_result = '0, mwb_result = '0;

    logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_illegal;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .stall(stall), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // The instruction currently sitting in EX, as the model sees it
    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, imm, d1, d2;
    } insn_t;

    insn_t m;

    function automatic logic known_op(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction

    function automatic logic [3:0] exp_op(input insn_t i);
        logic [3:0] tbl [8];
        tbl = '{4'd2, 4'd4, 4'd8, 4'd7, 4'd3, 4'd5, 4'd1, 4'd0};
        if (!i.v) return 4'd2;
        if (i.op == 7'h33 || i.op == 7'h13) begin
            if (i.f3 == 3'd0) return (i.op == 7'h33 && i.f7) ? 4'd6 : 4'd2;
            if (i.f3 == 3'd5) return i.f7 ? 4'd9 : 4'd5;
            return tbl[i.f3];
        end
        if (i.op == 7'h63) begin
            if (i.f3 == 3'd4 || i.f3 == 3'd5) return 4'd8;
            if (i.f3 == 3'd6 || i.f3 == 3'd7) return 4'd7;
            return 4'd6;
        end
        return 4'd2;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d);
        if (rs == 0) return d;
        if (exm_regwrite && exm_rd == rs) return exm_result;
        if (mwb_regwrite && mwb_rd == rs) return mwb_result;
        return d;
    endfunction

    function automatic logic model_hazard();
        logic uses2;
        uses2 = id_opcode inside {7'h33, 7'h23, 7'h63};
        return m.v && m.op == 7'h03 && m.rd != 0 && id_valid &&
               (id_rs1 == m.rd || (uses2 && id_rs2 == m.rd));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '{default: '0};
        end else if (flush) begin
            m.v = 1'b0;
        end else if (!stall) begin
            if (model_hazard() || !id_valid) begin
                m.v = 1'b0;
            end else begin
                m = '{v: 1'b1, op: id_opcode, f3: id_funct3, f7: id_funct7b5, rs1: id_rs1,
                      rs2: id_rs2, rd: id_rd, pc: id_pc, imm: id_imm, d1: id_rs1_data,
                      d2: id_rs2_data};
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ea, eb, r2;
        logic [3:0]  eop;
        chk("m_ex_valid", 32'(ex_valid), 32'(m.v));
        chk("m_hazard", 32'(hazard_stall), 32'(model_hazard()));
        chk("m_reg_write", 32'(ex_reg_write), 32'(m.v && writes_rd(m.op) && m.rd != 0));
        chk("m_mem_read", 32'(ex_mem_read), 32'(m.v && m.op == 7'h03));
        chk("m_mem_write", 32'(ex_mem_write), 32'(m.v && m.op == 7'h23));
        chk("m_branch", 32'(ex_branch), 32'(m.v && m.op == 7'h63));
        chk("m_illegal", 32'(ex_illegal), 32'(m.v && !known_op(m.op)));
        eop = exp_op(m);
        chk("m_alu_op", 32'(alu_op), 32'(eop));
        if (m.v) begin
            r2 = fwd(m.rs2, m.d2);
            if (m.op == 7'h37) ea = 0;
            else if (m.op inside {7'h17, 7'h6F, 7'h67}) ea = m.pc;
            else ea = fwd(m.rs1, m.d1);
            if (m.op inside {7'h33, 7'h63}) eb = r2;
            else if (m.op inside {7'h6F, 7'h67}) eb = 4;
            else eb = m.imm;
            if (eop inside {4'd4, 4'd5, 4'd9}) eb = eb % 32;
            chk("m_alu_a", alu_a, ea);
            chk("m_alu_b", alu_b, eb);
            chk("m_store_data", ex_store_data, r2);
            chk("m_ex_rd", 32'(ex_rd), 32'(m.rd));
            chk("m_ex_funct3", 32'(ex_funct3), 32'(m.f3));
            chk("m_ex_pc", ex_pc, m.pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pc);
        id_valid = 1'b1;
        id_opcode = op; id_funct3 = f3; id_funct7b5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_imm = imm; id_rs1_data = d1; id_rs2_data = d2; id_pc = pc;
    endtask

    task automatic clr_fwd();
        exm_regwrite = 0; exm_rd = 0; exm_result = 0;
        mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    initial begin
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_alu_op", 32'(alu_op), 32'h2);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_hazard", 32'(hazard_stall), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(7'h33, 3'd0, 0, 5'd1, 5'd2, 5'd3, 0, 32'd5, 32'd7, 32'h100);
        tick(); #1;
        chk("add_op", 32'(alu_op), 32'h2);
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 7);
        chk("add_rw", 32'(ex_reg_write), 1);
        chk("add_rd", 32'(ex_rd), 3);

        issue(7'h33, 3'd0, 1, 5'd1, 5'd2, 5'd4, 0, 32'd1, 32'd2, 32'h104);
        tick();
        exm_regwrite = 1; exm_rd = 1; exm_result = 100;
        mwb_regwrite = 1; mwb_rd = 1; mwb_result = 50;
        #1;
        chk("sub_op", 32'(alu_op), 32'h6);
        chk("sub_fwd_exm", alu_a, 100);
        chk("sub_b", alu_b, 2);
        exm_rd = 0; #1;
        chk("sub_fwd_mwb", alu_a, 50);
        mwb_regwrite = 0; #1;
        chk("sub_nofwd", alu_a, 1);
        clr_fwd();

        issue(7'h13, 3'd5, 1, 5'd7, 5'd4, 5'd8, 32'h404, 32'h8000_0000, 0, 32'h108);
        tick(); #1;
        chk("srai_op", 32'(alu_op), 32'h9);
        chk("srai_b", alu_b, 4);

        issue(7'h33, 3'd1, 0, 5'd7, 5'd9, 5'd8, 0, 32'h1, 32'h123, 32'h10C);
        tick(); #1;
        chk("sll_b", alu_b, 3);

        issue(7'h63, 3'd6, 0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd3, 32'd4, 32'h110);
        tick(); #1;
        chk("bltu_op", 32'(alu_op), 32'h7);
        chk("bltu_rw", 32'(ex_reg_write), 0);

        issue(7'h7F, 3'd0, 0, 5'd1, 5'd2, 5'd9, 0, 0, 0, 32'h114);
        tick(); #1;
        chk("ill_flag", 32'(ex_illegal), 1);
        chk("ill_rw", 32'(ex_reg_write), 0);

        issue(7'h6F, 3'd0, 0, 5'd0, 5'd0, 5'd1, 32'h40, 0, 0, 32'h200);
        tick(); #1;
        chk("jal_a", alu_a, 32'h200);
        chk("jal_b", alu_b, 4);

        issue(7'h03, 3'd2, 0, 5'd2, 5'd0, 5'd5, 32'd8, 32'h1000, 0, 32'h204);
        tick();
        issue(7'h33, 3'd0, 0, 5'd5, 5'd1, 5'd6, 0, 32'h11, 32'h22, 32'h208);
        #1;
        chk("lu_hazard", 32'(hazard_stall), 1);
        tick(); #1;
        chk("lu_bubble", 32'(ex_valid), 0);
        chk("lu_hazard_off", 32'(hazard_stall), 0);
        tick(); #1;
        chk("lu_loaded", 32'(ex_valid), 1);
        chk("lu_rd", 32'(ex_rd), 6);

        issue(7'h03, 3'd2, 0, 5'd2, 5'd0, 5'd5, 32'd8, 32'h1000, 0, 32'h20C);
        tick();
        issue(7'h13, 3'd0, 0, 5'd1, 5'd5, 5'd7, 32'd1, 32'd9, 0, 32'h210);
        #1;
        chk("addi_rs2_nohaz", 32'(hazard_stall), 0);
        tick();

        issue(7'h33, 3'd0, 0, 5'd1, 5'd2, 5'd8, 0, 32'd1, 32'd1, 32'h214);
        tick();
        flush = 1; stall = 1;
        tick(); #1;
        chk("flush_wins", 32'(ex_valid), 0);
        flush = 0; stall = 0;

        issue(7'h13, 3'd6, 0, 5'd3, 5'd0, 5'd10, 32'h0F, 32'hF0, 0, 32'h218);
        tick();
        stall = 1;
        issue(7'h33, 3'd0, 0, 5'd1, 5'd2, 5'd11, 0, 0, 0, 32'h21C);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin exm_regwrite = 1; exm_rd = 3; exm_result = 32'hAA; end
            tick(); #1;
            chk("stall_rd", 32'(ex_rd), 10);
            chk("stall_op", 32'(alu_op), 32'h1);
            chk("stall_a", alu_a, (k == 0) ? 32'hF0 : 32'hAA);
        end
        stall = 0;
        clr_fwd();
        tick();

        issue(7'h33, 3'd0, 0, 5'd1, 5'd2, 5'd3, 0, 32'd5, 32'd7, 32'h300);
        tick(); #2;
        rst_n = 1'b0; #1;
        chk("arst_valid", 32'(ex_valid), 0);
        chk("arst_op", 32'(alu_op), 32'h2);
        chk("arst_a", alu_a, 0);
        chk("arst_rw", 32'(ex_reg_write), 0);
        id_valid = 0;
        tick();
        rst_n = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
